// File: rtl/chunked_adder.sv
// -----------------------------------------------------------------------------
// chunked_adder
//
// Multi-cycle adder/subtractor. A WIDTH-bit add or subtract is done CHUNK bits
// per clock, least significant chunk first. The carry between chunks is kept in
// a register, so the longest carry chain is only CHUNK bits. Operands arrive on
// a valid/ready handshake and the result leaves on a second one.
//
// Ports
//   clk        in   clock, every flop uses the rising edge
//   rst        in   synchronous reset, active high
//   in_valid   in   a, b, sub and carry_in are valid
//   in_ready   out  block is idle and can accept operands (comb. from state)
//   a          in   operand A (unsigned or two's complement)
//   b          in   operand B
//   sub        in   0 = a + b + carry_in, 1 = a - b
//   carry_in   in   carry into the LSB for add, ignored for subtract
//   out_valid  out  sum / carry_out / overflow are valid
//   out_ready  in   consumer takes the result
//   sum        out  result modulo 2^WIDTH
//   carry_out  out  carry out of the MSB (for subtract: 1 = no borrow)
//   overflow   out  signed overflow (carry into MSB xor carry out of MSB)
//
// The file also holds chunked_adder_chk, a small assertion checker that the
// top level instantiates. Synthesis ignores its concurrent assertions.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// chunked_adder_chk
//
// Handshake properties of chunked_adder, observed from its ports only.
//
// Ports
//   clk, rst        clock and synchronous reset of the checked block
//   in_ready        input-side ready
//   out_valid       output-side valid
//   out_ready       output-side ready
//   sum, carry_out, overflow   result bus that must stay stable while stalled
// -----------------------------------------------------------------------------
module chunked_adder_chk #(
  parameter int WIDTH = 16
) (
  input logic             clk,
  input logic             rst,
  input logic             in_ready,
  input logic             out_valid,
  input logic             out_ready,
  input logic [WIDTH-1:0] sum,
  input logic             carry_out,
  input logic             overflow
);

  // The block is never ready for new operands while a result is waiting.
  a_no_ready_while_valid : assert property (
    @(posedge clk) disable iff (rst)
      !(in_ready && out_valid)
  );

  // A stalled result stays valid and its value does not move.
  a_result_held_under_backpressure : assert property (
    @(posedge clk) disable iff (rst)
      (out_valid && !out_ready) |=>
        (out_valid && $stable(sum) && $stable(carry_out) && $stable(overflow))
  );

endmodule : chunked_adder_chk

// -----------------------------------------------------------------------------
// chunked_adder (top)
// -----------------------------------------------------------------------------
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  // Guard against a zero divisor so a bad CHUNK reports the error below
  // instead of failing inside the NCHUNK arithmetic.
  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCHUNK     = WIDTH / CHUNK_SAFE;
  localparam int CW         = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NCHUNK - 1);

  if ((CHUNK < 1) || ((WIDTH % CHUNK_SAFE) != 0)) begin : g_bad_param
    $error("chunked_adder: CHUNK must be >= 1 and divide WIDTH (WIDTH=%0d CHUNK=%0d)",
           WIDTH, CHUNK);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Chunk adder. Returns {carry_out, carry_into_msb, sum[CHUNK-1:0]}.
  // The carry into the MSB is recovered as s ^ x ^ y at the top bit, which
  // holds for any CHUNK, including CHUNK = 1 where it equals cin.
  function automatic logic [CHUNK+1:0] chunk_add(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             cin
  );
    logic [CHUNK:0] t;
    t = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
    chunk_add = {t[CHUNK], t[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1], t[CHUNK-1:0]};
  endfunction

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  // a_r shifts right one chunk per RUN cycle. The freed top chunk receives the
  // chunk sum, so after NCHUNK cycles a_r holds the complete result and no
  // separate partial-sum register is needed.
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_out_r;
  logic             overflow_r;

  logic [CHUNK+1:0] add_s;
  logic [CHUNK-1:0] chunk_sum_s;
  logic             chunk_cout_s;
  logic             chunk_cmsb_s;
  logic [WIDTH-1:0] a_next_s;
  logic [WIDTH-1:0] b_next_s;
  logic             last_s;

  // Split the chunk-adder result for the low chunk of the operand registers.
  always_comb begin
    add_s        = chunk_add(a_r[CHUNK-1:0], b_r[CHUNK-1:0], carry_r);
    chunk_cout_s = add_s[CHUNK+1];
    chunk_cmsb_s = add_s[CHUNK];
    chunk_sum_s  = add_s[CHUNK-1:0];
    b_next_s     = b_r >> CHUNK;
    last_s       = (cnt_r == LAST_IDX);
  end

  if (CHUNK == WIDTH) begin : g_single_chunk
    // Next value of the operand/result shift register (single chunk).
    always_comb begin
      a_next_s = chunk_sum_s;
    end
  end else begin : g_multi_chunk
    // Next value of the operand/result shift register (multi chunk).
    always_comb begin
      a_next_s = {chunk_sum_s, a_r[WIDTH-1:CHUNK]};
    end
  end

  // Control FSM, operand/carry datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      carry_r     <= 1'b0;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      sum_r       <= {WIDTH{1'b0}};
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            // Subtract is a + ~b + 1, so only B and the initial carry change.
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub ? 1'b1 : carry_in;
            cnt_r   <= {CW{1'b0}};
            state_r <= RUN;
          end
        end

        RUN: begin
          a_r     <= a_next_s;
          b_r     <= b_next_s;
          carry_r <= chunk_cout_s;
          cnt_r   <= cnt_r + CW'(1);
          if (last_s) begin
            sum_r       <= a_next_s;
            carry_out_r <= chunk_cout_s;
            overflow_r  <= chunk_cout_s ^ chunk_cmsb_s;
            out_valid_r <= 1'b1;
            cnt_r       <= {CW{1'b0}};
            state_r     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end

        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  // Port drive: ready is decoded from state and gated by reset.
  always_comb begin
    in_ready  = (state_r == IDLE) && !rst;
    out_valid = out_valid_r;
    sum       = sum_r;
    carry_out = carry_out_r;
    overflow  = overflow_r;
  end

  chunked_adder_chk #(
    .WIDTH(WIDTH)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

endmodule : chunked_adder
